// File: rtl/madd_err_eval_pkg.sv
// Shared types and helpers for the approximate multiply-add error evaluator.
package madd_eval_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int ABS_W = 64;

   function automatic int stim_w(input int w);
      return 3 * w;
   endfunction

   function automatic int res_w(input int w);
      return 2 * w;
   endfunction

   function automatic int cnt_w(input int w);
      return 3 * w + 1;
   endfunction

   function automatic int max_w(input int w);
      return 2 * w + 1;
   endfunction

   function automatic int sum_w(input int w);
      return 5 * w + 1;
   endfunction

   function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                 input logic [ABS_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/madd_err_eval_if.sv
// Stimulus/result and status bundle between the evaluator and its harness.
interface madd_err_eval_if #(
   parameter int W = 6
);
   import madd_eval_pkg::*;

   logic                    start_i;
   logic                    pause_i;
   logic [stim_w(W)-1:0]    stim_o;
   logic [res_w(W)-1:0]     dut_res_i;
   logic                    busy_o;
   logic                    done_o;
   logic [cnt_w(W)-1:0]     err_cnt_o;
   logic [max_w(W)-1:0]     max_err_o;
   logic [sum_w(W)-1:0]     sum_err_o;

   modport master (
      input  start_i, pause_i, dut_res_i,
      output stim_o, busy_o, done_o, err_cnt_o, max_err_o, sum_err_o
   );

   modport slave (
      output start_i, pause_i, dut_res_i,
      input  stim_o, busy_o, done_o, err_cnt_o, max_err_o, sum_err_o
   );

endinterface

// File: rtl/madd_exact_ref.sv
// Exact a*b+c reference, widened to 2W+1 bits so nothing is truncated.
module madd_exact_ref #(
   parameter int W = 6
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [2*W:0] exact
);
   localparam int EW = 2 * W + 1;

   always_comb begin
      exact = EW'(a) * EW'(b) + EW'(c);
   end

endmodule

// File: rtl/madd_err_eval.sv
// Sweeps every (a,b,c) vector through an external approximate multiply-add
// and accumulates error count, max and sum against the exact result.
module madd_err_eval
   import madd_eval_pkg::*;
#(
   parameter int W       = 6,
   parameter int DUT_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   madd_err_eval_if.master bus
);
   localparam int SW = stim_w(W);
   localparam int CW = cnt_w(W);
   localparam int EW = max_w(W);
   localparam int UW = sum_w(W);

   state_t          state;
   logic [SW-1:0]   cnt;
   logic [DUT_LAT-1:0] vld;
   logic [EW-1:0]   ex_pipe [DUT_LAT];
   logic [EW-1:0]   exact_now;
   logic [EW-1:0]   err;
   logic            issue;

   // Exact value is computed from the vector being issued and carried with its token.
   madd_exact_ref #(.W(W)) u_ref (
      .a     (cnt[W-1:0]),
      .b     (cnt[2*W-1:W]),
      .c     (cnt[3*W-1:2*W]),
      .exact (exact_now)
   );

   always_comb begin
      issue = (state == RUN) && !bus.pause_i;
      err   = EW'(abs_diff(ABS_W'(ex_pipe[DUT_LAT-1]), ABS_W'(bus.dut_res_i)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         vld           <= '0;
         bus.stim_o    <= '0;
         bus.busy_o    <= 1'b0;
         bus.done_o    <= 1'b0;
         bus.err_cnt_o <= '0;
         bus.max_err_o <= '0;
         bus.sum_err_o <= '0;
         for (int unsigned i = 0; i < DUT_LAT; i++) begin
            ex_pipe[i] <= '0;
         end
      end else begin
         vld[0]     <= issue;
         ex_pipe[0] <= exact_now;
         for (int unsigned i = 1; i < DUT_LAT; i++) begin
            vld[i]     <= vld[i-1];
            ex_pipe[i] <= ex_pipe[i-1];
         end

         if (vld[DUT_LAT-1]) begin
            bus.err_cnt_o <= bus.err_cnt_o + CW'(err != '0);
            bus.sum_err_o <= bus.sum_err_o + UW'(err);
            if (err > bus.max_err_o) begin
               bus.max_err_o <= err;
            end
         end

         case (state)
            IDLE, DONE: begin
               if (bus.start_i) begin
                  state         <= RUN;
                  cnt           <= '0;
                  bus.busy_o    <= 1'b1;
                  bus.done_o    <= 1'b0;
                  bus.err_cnt_o <= '0;
                  bus.max_err_o <= '0;
                  bus.sum_err_o <= '0;
               end
            end
            RUN: begin
               if (!bus.pause_i) begin
                  bus.stim_o <= cnt;
                  cnt        <= cnt + 1'b1;
                  if (cnt == '1) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (vld == '0) begin
                  state      <= DONE;
                  bus.busy_o <= 1'b0;
                  bus.done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
